// File: rtl/cbx_cfg_pkg.sv
// Shared types and helpers for the parametrised X-channel connection block.
// Holds the loader FSM states, the tap map and parameter legality checks.
package cbx_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    DONE
  } cfg_state_t;

  // track feeding tap pair k of ipin i
  function automatic int tap_track(
    input int i,
    input int k,
    input int stride,
    input int chan_w
  );
    return (i + k * stride) % chan_w;
  endfunction

  // selector must pair left/right taps and cannot need more than both sides
  function automatic bit mux_size_legal(
    input int mux_size,
    input int chan_w
  );
    return (mux_size >= 2) && (mux_size % 2 == 0)
        && (mux_size <= 2 * chan_w);
  endfunction

endpackage

// File: rtl/cbx_ipin_mux.sv
// One ipin selector: picks one of MUX_SIZE taps, forced low when disabled.
// Select codes at or above MUX_SIZE also give 0.
module cbx_ipin_mux #(
  parameter int MUX_SIZE = 6,
  parameter int SEL_W    = $clog2(MUX_SIZE)
) (
  input  logic [MUX_SIZE-1:0] taps,
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic                out
);

  // compare-and-pick keeps indexing inside the tap vector
  always_comb begin
    out = 1'b0;
    if (en) begin
      for (int j = 0; j < MUX_SIZE; j++) begin
        if (sel == SEL_W'(j)) out = taps[j];
      end
    end
  end

endmodule

// File: rtl/cbx_param_cfg.sv
// Parametrised X-channel connection block with handshaked shadow/active loader.
// Optional readback of the active config: define CBX_READBACK_EN.
module cbx_param_cfg
  import cbx_cfg_pkg::*;
#(
  parameter int CHAN_W   = 13,
  parameter int NUM_IPIN = 11,
  parameter int MUX_SIZE = 6,
  parameter int STRIDE   = 6,
  parameter int SEL_W    = $clog2(MUX_SIZE),
  parameter int ADDR_W   = (NUM_IPIN > 1) ? $clog2(NUM_IPIN) : 1
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic                cfg_commit,
  output logic                cfg_err,
  output logic                cfg_done
`ifdef CBX_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SEL_W-1:0]    rd_sel,
  output logic                rd_vld
`endif
);

  if (!mux_size_legal(MUX_SIZE, CHAN_W)) begin : g_bad_mux
    $error("cbx_param_cfg: MUX_SIZE must be even and <= 2*CHAN_W");
  end

  cfg_state_t state_q, state_d;

  logic [SEL_W-1:0]    sh_sel  [NUM_IPIN];
  logic [SEL_W-1:0]    act_sel [NUM_IPIN];
  logic [NUM_IPIN-1:0] sh_vld;
  logic [NUM_IPIN-1:0] act_vld;
  logic                err_q;
  logic                accept;
  logic                addr_ok;
  logic                sel_ok;
  logic                wr_ok;

  logic [MUX_SIZE-1:0] taps [NUM_IPIN];

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  assign accept  = cfg_valid & cfg_ready;
  assign addr_ok = {1'b0, cfg_addr} < (ADDR_W+1)'(NUM_IPIN);
  assign sel_ok  = {1'b0, cfg_sel} < (SEL_W+1)'(MUX_SIZE);
  assign wr_ok   = accept & addr_ok & sel_ok;

  assign cfg_err  = err_q;
  assign cfg_done = (state_q == DONE);

  // loader state register
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and handshake ready
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_commit) state_d = COMMIT;
      end
      COMMIT:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // shadow writes; last write to an address wins
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sh_vld <= '0;
      for (int i = 0; i < NUM_IPIN; i++) sh_sel[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_IPIN; i++) begin
        if (cfg_addr == ADDR_W'(i)) begin
          sh_sel[i] <= cfg_sel;
          sh_vld[i] <= 1'b1;
        end
      end
    end
  end

  // atomic shadow-to-active copy, all ipins on one edge
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      act_vld <= '0;
      for (int i = 0; i < NUM_IPIN; i++) act_sel[i] <= '0;
    end else if (state_q == COMMIT) begin
      act_vld <= sh_vld;
      for (int i = 0; i < NUM_IPIN; i++) act_sel[i] <= sh_sel[i];
    end
  end

  // rejected write reported one cycle later
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) err_q <= 1'b0;
    else        err_q <= accept & ~(addr_ok & sel_ok);
  end

  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
    for (genvar k = 0; k < MUX_SIZE / 2; k++) begin : g_tap
      assign taps[i][2*k] =
        chanx_left_in[tap_track(i, k, STRIDE, CHAN_W)];
      assign taps[i][2*k+1] =
        chanx_right_in[tap_track(i, k, STRIDE, CHAN_W)];
    end

    cbx_ipin_mux #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_mux (
      .taps (taps[i]),
      .sel  (act_sel[i]),
      .en   (act_vld[i]),
      .out  (ipin_out[i])
    );
  end

`ifdef CBX_READBACK_EN
  // registered readback; out-of-range address reads 0/0
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      rd_sel <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_sel <= '0;
      rd_vld <= 1'b0;
      for (int i = 0; i < NUM_IPIN; i++) begin
        if (rd_addr == ADDR_W'(i)) begin
          rd_sel <= act_sel[i];
          rd_vld <= act_vld[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cbx_param_cfg.sv
// Self-checking bench for cbx_param_cfg: directed table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_cbx_param_cfg;

  localparam int CHAN_W   = 13;
  localparam int NUM_IPIN = 11;
  localparam int MUX_SIZE = 6;
  localparam int STRIDE   = 6;
  localparam int SEL_W    = 3;
  localparam int ADDR_W   = 4;

  logic                prog_clk = 1'b0;
  logic                pReset;
  logic [CHAN_W-1:0]   chanx_left_in;
  logic [CHAN_W-1:0]   chanx_right_in;
  logic [CHAN_W-1:0]   chanx_left_out;
  logic [CHAN_W-1:0]   chanx_right_out;
  logic [NUM_IPIN-1:0] ipin_out;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [SEL_W-1:0]    cfg_sel;
  logic                cfg_commit;
  logic                cfg_err;
  logic                cfg_done;
`ifdef CBX_READBACK_EN
  logic [ADDR_W-1:0]   rd_addr;
  logic [SEL_W-1:0]    rd_sel;
  logic                rd_vld;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: spec-level shadow/active tables and loader phase
  int m_sh_sel  [NUM_IPIN];
  bit m_sh_vld  [NUM_IPIN];
  int m_act_sel [NUM_IPIN];
  bit m_act_vld [NUM_IPIN];
  int m_phase;
  bit m_err;
  int m_rd_sel;
  bit m_rd_vld;

  cbx_param_cfg dut (
    .prog_clk        (prog_clk),
    .pReset          (pReset),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .ipin_out        (ipin_out),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_addr        (cfg_addr),
    .cfg_sel         (cfg_sel),
    .cfg_commit      (cfg_commit),
    .cfg_err         (cfg_err),
    .cfg_done        (cfg_done)
`ifdef CBX_READBACK_EN
    ,
    .rd_addr         (rd_addr),
    .rd_sel          (rd_sel),
    .rd_vld          (rd_vld)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_IPIN; i++) begin
      m_sh_sel[i] = 0; m_sh_vld[i] = 0;
      m_act_sel[i] = 0; m_act_vld[i] = 0;
    end
    m_phase = 0; m_err = 0; m_rd_sel = 0; m_rd_vld = 0;
  endtask

  function automatic logic [NUM_IPIN-1:0] exp_ipin();
    logic [NUM_IPIN-1:0] r = '0;
    for (int i = 0; i < NUM_IPIN; i++) begin
      if (m_act_vld[i]) begin
        int s = m_act_sel[i];
        int t = (i + (s / 2) * STRIDE) % CHAN_W;
        r[i] = (s % 2 == 0) ? chanx_left_in[t] : chanx_right_in[t];
      end
    end
    return r;
  endfunction

  // one clock edge, model advanced with the pre-edge inputs
  task automatic cycle();
    bit acc = (m_phase == 0) && cfg_valid;
    bit n_err = 0;
    int n_phase = m_phase;
`ifdef CBX_READBACK_EN
    if (int'(rd_addr) < NUM_IPIN) begin
      m_rd_sel = m_act_sel[rd_addr];
      m_rd_vld = m_act_vld[rd_addr];
    end else begin
      m_rd_sel = 0; m_rd_vld = 0;
    end
`endif
    if (m_phase == 1) begin
      for (int i = 0; i < NUM_IPIN; i++) begin
        m_act_sel[i] = m_sh_sel[i];
        m_act_vld[i] = m_sh_vld[i];
      end
    end
    if (acc) begin
      if (int'(cfg_addr) < NUM_IPIN && int'(cfg_sel) < MUX_SIZE) begin
        m_sh_sel[cfg_addr] = cfg_sel;
        m_sh_vld[cfg_addr] = 1;
      end else n_err = 1;
    end
    if (m_phase == 0) n_phase = cfg_commit ? 1 : 0;
    else if (m_phase == 1) n_phase = 2;
    else n_phase = 0;
    @(posedge prog_clk);
    m_phase = n_phase;
    m_err = n_err;
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".left_out"}, 32'(chanx_left_out), 32'(chanx_right_in));
    chk({tag, ".right_out"}, 32'(chanx_right_out), 32'(chanx_left_in));
    chk({tag, ".ipin"}, 32'(ipin_out), 32'(exp_ipin()));
    chk({tag, ".ready"}, 32'(cfg_ready), 32'(m_phase == 0));
    chk({tag, ".err"}, 32'(cfg_err), 32'(m_err));
    chk({tag, ".done"}, 32'(cfg_done), 32'(m_phase == 2));
`ifdef CBX_READBACK_EN
    chk({tag, ".rd_sel"}, 32'(rd_sel), 32'(m_rd_sel));
    chk({tag, ".rd_vld"}, 32'(rd_vld), 32'(m_rd_vld));
`endif
  endtask

  task automatic write(input int a, input int s, input bit c);
    cfg_valid = 1; cfg_addr = ADDR_W'(a); cfg_sel = SEL_W'(s);
    cfg_commit = c;
    cycle();
    cfg_valid = 0; cfg_commit = 0;
  endtask

  task automatic commit_wait(input string tag);
    cfg_commit = 1;
    cycle();
    cfg_commit = 0;
    chk({tag, ".commit_ready"}, 32'(cfg_ready), 32'd0);
    cycle();
    chk({tag, ".done"}, 32'(cfg_done), 32'd1);
    chk_all(tag);
    cycle();
    chk({tag, ".done_clear"}, 32'(cfg_done), 32'd0);
  endtask

  typedef struct {
    logic [CHAN_W-1:0] left;
    logic [CHAN_W-1:0] right;
    logic              exp0;
    logic              exp1;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{13'h0040, 13'h0000, 1'b1, 1'b0};
    vecs[1] = '{13'h1fbf, 13'h1fff, 1'b0, 1'b1};
    vecs[2] = '{13'h0000, 13'h0001, 1'b0, 1'b1};
    vecs[3] = '{13'h1fff, 13'h1ffe, 1'b1, 1'b0};

    pReset = 1; cfg_valid = 0; cfg_commit = 0;
    cfg_addr = '0; cfg_sel = '0;
    chanx_left_in = '0; chanx_right_in = '0;
`ifdef CBX_READBACK_EN
    rd_addr = '0;
`endif
    model_reset();
    #12;
    chanx_left_in = 13'h1555;
    #1;
    chk("rst.right_out", 32'(chanx_right_out), 32'h1555);
    chk("rst.ipin", 32'(ipin_out), 32'd0);
    chk("rst.ready", 32'(cfg_ready), 32'd1);
    chk("rst.err", 32'(cfg_err), 32'd0);
    chk("rst.done", 32'(cfg_done), 32'd0);
    @(negedge prog_clk);
    pReset = 0;
    @(posedge prog_clk); #1;

    // basic writes and commit
    write(0, 2, 0);
    chk_all("t2.w0");
    write(1, 5, 0);
    chk_all("t2.w1");
    chk("t2.pre_commit_ipin", 32'(ipin_out), 32'd0);
    commit_wait("t2");
    foreach (vecs[v]) begin
      chanx_left_in = vecs[v].left;
      chanx_right_in = vecs[v].right;
      #1;
      chk($sformatf("tab%0d.ipin0", v), 32'(ipin_out[0]),
          32'(vecs[v].exp0));
      chk($sformatf("tab%0d.ipin1", v), 32'(ipin_out[1]),
          32'(vecs[v].exp1));
      chk_all($sformatf("tab%0d", v));
    end

`ifdef CBX_READBACK_EN
    rd_addr = 4'd1;
    cycle();
    chk("rb.sel1", 32'(rd_sel), 32'd5);
    chk("rb.vld1", 32'(rd_vld), 32'd1);
    rd_addr = 4'd12;
    cycle();
    chk("rb.sel12", 32'(rd_sel), 32'd0);
    chk("rb.vld12", 32'(rd_vld), 32'd0);
`endif

    // rejected write
    write(3, 6, 0);
    chk("t3.err", 32'(cfg_err), 32'd1);
    chk_all("t3.w");
    cycle();
    chk("t3.err_clear", 32'(cfg_err), 32'd0);
    commit_wait("t3");
    chanx_left_in = '1; chanx_right_in = '1; #1;
    chk("t3.ipin3", 32'(ipin_out[3]), 32'd0);

    // write in the commit cycle joins that commit
    write(4, 1, 1);
    cycle();
    chk("t4.done", 32'(cfg_done), 32'd1);
    chanx_right_in = 13'h0010; chanx_left_in = '0; #1;
    chk("t4.ipin4_hi", 32'(ipin_out[4]), 32'd1);
    chanx_right_in = 13'h1fef; chanx_left_in = '1; #1;
    chk("t4.ipin4_lo", 32'(ipin_out[4]), 32'd0);
    chk_all("t4");
    cycle();

    // reset in the middle of a commit
    write(2, 3, 1);
    chk("t5.in_commit", 32'(cfg_ready), 32'd0);
    pReset = 1; #1;
    model_reset();
    chk("t5.ipin", 32'(ipin_out), 32'd0);
    chk("t5.ready", 32'(cfg_ready), 32'd1);
    chk("t5.done", 32'(cfg_done), 32'd0);
    chk("t5.err", 32'(cfg_err), 32'd0);
    @(negedge prog_clk);
    pReset = 0;
    @(posedge prog_clk); #1;
    commit_wait("t5.empty");
    chk("t5.empty_ipin", 32'(ipin_out), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_addr = ADDR_W'($urandom_range(0, 15));
      cfg_sel = SEL_W'($urandom_range(0, 7));
      cfg_commit = ($urandom_range(0, 7) == 0);
      chanx_left_in = CHAN_W'($urandom);
      chanx_right_in = CHAN_W'($urandom);
`ifdef CBX_READBACK_EN
      rd_addr = ADDR_W'($urandom_range(0, 15));
`endif
      cycle();
      chk_all($sformatf("rnd%0d", n));
      chanx_left_in = CHAN_W'($urandom);
      chanx_right_in = CHAN_W'($urandom);
      #1;
      chk($sformatf("rnd%0d.comb", n), 32'(ipin_out), 32'(exp_ipin()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
